alu_addsub_ctrl: RTL
====================

// Module: alu_addsub_ctrl
// PURPOSE
//  Sequencer directly upstream of the 16-bit ripple-CLA adder. Accepts ADD/SUB/INC/DEC/CMP
//  requests over a valid/ready handshake and maps each opcode to adder operands and c_in.
//  Drives the adder's level enable, waits for its ready, and registers the sum and the ZNCV
//  flags. Returns the result on a valid/ready response port; a watchdog bounds the wait.
// PARAMETERS
//  WIDTH     16  datapath width; must equal the adder width
//  TIMEOUT   15  max cycles in RUN before the op is aborted with rsp_err
//  CNT_W     4   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  req_valid    in   1      request present
//  req_ready    out  1      controller can accept (high only in IDLE)
//  req_op       in   3      0 ADD, 1 SUB, 2 INC, 3 DEC, 4 CMP, 5-7 illegal
//  req_a        in   WIDTH  operand A
//  req_b        in   WIDTH  operand B; ignored for INC/DEC
//  add_en       out  1      adder enable; level, registered
//  add_a        out  WIDTH  adder A; registered, stable while add_en=1
//  add_b        out  WIDTH  adder B before the adder's internal XOR with c_in
//  add_cin      out  1      adder c_in; 1 selects subtract (adder computes A+~B+1)
//  add_sum      in   WIDTH  adder Output
//  add_cout     in   1      adder c_out
//  add_ready    in   1      adder ready
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      consumer accepts response
//  rsp_result   out  WIDTH  sum; 0 on error
//  rsp_flags    out  4      {Z,N,C,V}; 0 on error
//  rsp_wr       out  1      1 = write result back (0 for CMP and for errors)
//  rsp_err      out  1      illegal opcode or watchdog timeout
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
//  - Reset state: IDLE; req_ready=1 and every other output 0, counter 0.
//  - FSM states: IDLE, RUN, RESP.
//  - IDLE: accept when req_valid&&req_ready.
//    Legal opcode: latch operands, set add_en=1, counter=0, go RUN.
//    Illegal opcode: rsp_err=1, rsp_wr=0, result and flags 0, go RESP. The adder is not touched.
//  - Opcode mapping (add_a=req_a in every case):
//    ADD  b=B, cin=0.  SUB/CMP  b=B, cin=1.  INC  b=1, cin=0.  DEC  b=1, cin=1.
//  - RUN: counter increments each cycle.
//    On the first edge with add_ready=1, register add_sum as the result and compute flags.
//    On that same edge, clear add_en and go RESP.
//    If the counter reaches TIMEOUT first: add_en=0, rsp_err=1, result 0, go RESP.
//    add_ready is ignored in IDLE and in RESP.
//  - Flags: Z=(sum==0); N=sum[WIDTH-1]; C=add_cout, where C=1 on sub/dec means no borrow.
//    b_eff=add_b^{WIDTH{add_cin}}; V=(a[MSB]==b_eff[MSB])&&(sum[MSB]!=a[MSB]).
//  - RESP: rsp_valid=1; all rsp_* outputs are held stable until rsp_valid&&rsp_ready.
//    On that handshake go IDLE. add_en stays 0 for at least 2 edges between ops, which
//    guarantees the adder deasserts ready before the next enable.
//  - Latency: accept edge -> rsp_valid = adder ready latency + 1 cycle.
//    Back-to-back throughput is one op per (adder latency + 3) cycles.
//  - Reset mid-op: asynchronously return to IDLE, add_en=0, response dropped, no partial rsp.
//  - Wrap: 0xFFFF+1 -> 0x0000 with Z=1 C=1. 0x0000-1 -> 0xFFFF with N=1 C=0.
// STRUCTURE
//  - alu_pkg: opcode localparams (OP_ADD..OP_CMP), flag bit indices (FLG_Z=3..FLG_V=0),
//    and FSM state encodings.
//  - One sub-module: alu_flag_calc, combinational (sum, cout, a, b_eff -> ZNCV).
//    The controller registers its outputs.
//  - The FSM, operand mapping and watchdog live in this module.
// TESTING
//  Use a behavioural adder model that asserts ready 3 cycles after en and holds it until en drops.
//  1. ADD 0x1234+0x0001, rsp_ready=1 -> result 0x1235, flags 0000, wr=1, err=0.
//     rsp_valid appears 4 cycles after accept.
//  2. SUB 0x8000-0x0001 -> result 0x7FFF, flags 0011 (C=1, V=1).
//     CMP 5,5 -> result 0, flags 1010, wr=0.
//  3. INC 0xFFFF -> result 0x0000, flags 1010.
//     DEC 0x0000 -> result 0xFFFF, flags 0100.
//  4. req_op=6 -> rsp_err=1 on the next cycle, add_en never rises.
//     Adder model never readies -> err after TIMEOUT cycles, add_en low.
//  5. Hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout.
//     Then a back-to-back pair completes with add_en low for at least 2 edges between them.
//  6. rst_n pulsed low mid-RUN -> immediate IDLE, add_en=0, no rsp_valid.
//     A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encodings for the add/sub sequencer.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_INC = 3'd2;
    localparam logic [2:0] OP_DEC = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd4;

    // rsp_flags is packed {Z,N,C,V}
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational ZNCV derivation from the adder output. b_eff is the operand
// after the adder's internal inversion, so V is the plain same-sign overflow test.
module alu_flag_calc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] sum,
    input  logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_eff,
    output logic [3:0]       flags
);

    // Derive flags; C=1 on subtract means no borrow occurred
    always_comb begin
        flags        = '0;
        flags[FLG_Z] = (sum == '0);
        flags[FLG_N] = sum[WIDTH-1];
        flags[FLG_C] = cout;
        flags[FLG_V] = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_addsub_ctrl.sv
// Sequencer in front of the 16-bit adder: maps opcodes to operands/c_in,
// holds the adder enable until ready (or watchdog expiry) and returns a
// registered result with ZNCV flags over a valid/ready response port.
//
//  state | meaning
//  IDLE  | req_ready=1, waiting for a request; adder disabled
//  RUN   | add_en=1, waiting for add_ready; watchdog counting
//  RESP  | rsp_valid=1, response held until rsp_ready
module alu_addsub_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    input  logic             add_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_wr,
    output logic             rsp_err
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_wr;

    logic [WIDTH-1:0] map_b;
    logic             map_cin;
    logic             map_legal;
    logic             map_wr;

    logic [WIDTH-1:0] b_eff;
    logic [3:0]       flags_calc;

    assign b_eff = add_b ^ {WIDTH{add_cin}};

    alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .sum   (add_sum),
        .cout  (add_cout),
        .a     (add_a),
        .b_eff (b_eff),
        .flags (flags_calc)
    );

    // Opcode to adder operand mapping; INC/DEC replace B with the constant 1
    always_comb begin
        map_b     = req_b;
        map_cin   = 1'b0;
        map_legal = 1'b1;
        map_wr    = 1'b1;
        case (req_op)
            OP_ADD: map_cin = 1'b0;
            OP_SUB: map_cin = 1'b1;
            OP_INC: map_b   = WIDTH'(1);
            OP_DEC: begin
                map_b   = WIDTH'(1);
                map_cin = 1'b1;
            end
            OP_CMP: begin
                map_cin = 1'b1;
                map_wr  = 1'b0;
            end
            default: begin
                map_legal = 1'b0;
                map_wr    = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with watchdog; every output is registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_wr      <= 1'b0;
            req_ready  <= 1'b1;
            add_en     <= 1'b0;
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_wr     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (map_legal) begin
                            add_a   <= req_a;
                            add_b   <= map_b;
                            add_cin <= map_cin;
                            add_en  <= 1'b1;
                            op_wr   <= map_wr;
                            cnt     <= '0;
                            state   <= ST_RUN;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_wr     <= 1'b0;
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                            state      <= ST_RESP;
                        end
                    end
                end
                ST_RUN: begin
                    // ready wins over a watchdog expiry on the same edge
                    if (add_ready) begin
                        add_en     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= add_sum;
                        rsp_flags  <= flags_calc;
                        rsp_wr     <= op_wr;
                        rsp_err    <= 1'b0;
                        state      <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        cnt        <= cnt + 1'b1;
                        add_en     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_result <= '0;
                        rsp_flags  <= '0;
                        rsp_wr     <= 1'b0;
                        rsp_err    <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // passing through IDLE keeps add_en low for two edges before the next op
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    add_en    <= 1'b0;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
